// File: rtl/lock_burst_arbiter.sv
// lock_burst_arbiter: two-requester round-robin arbiter that grants fixed-length bursts.
// The owner may lock the grant so that it can issue further bursts without re-arbitration.
module lock_burst_arbiter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [2:0] burst_len_i,
    input  logic       lock_i,
    input  logic       unlock_i,
    output logic [1:0] gnt_o,
    output logic       burst_start_o,
    output logic       burst_end_o,
    output logic       data_valid_o,
    output logic       busy_o
);
    typedef enum logic [1:0] {IDLE, BURST, LOCKED} state_e;
    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [2:0] len_q, len_d, cnt_q, cnt_d;
    logic       owner_q, owner_d, rr_q, rr_d, lock_q, lock_d;
    logic       start_q, start_d, end_q, end_d, valid_q, valid_d, busy_q;
    logic       win;
    always_comb begin
        // rr_q holds the last owner; on a tie the other requester wins
        win     = (req_i == 2'b11) ? ~rr_q : req_i[1];
        lock_d  = unlock_i ? 1'b0 : ((lock_i && gnt_q != 2'b00) ? 1'b1 : lock_q);
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        end_d   = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (req_i != 2'b00) begin
                state_d = BURST;
                owner_d = win;
                rr_d    = win;
                gnt_d   = {win, ~win};
                len_d   = burst_len_i;
                cnt_d   = 3'd0;
                start_d = 1'b1;
                end_d   = (burst_len_i == 3'd0);
                valid_d = 1'b1;
            end
            BURST: if (cnt_q == len_q) begin
                state_d = lock_d ? LOCKED : IDLE;
                gnt_d   = lock_d ? gnt_q : 2'b00;
                cnt_d   = 3'd0;
            end else begin
                cnt_d   = cnt_q + 3'd1;
                end_d   = (cnt_q + 3'd1 == len_q);
                valid_d = 1'b1;
            end
            LOCKED: if (unlock_i) begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end else if (req_i[owner_q]) begin
                state_d = BURST;
                len_d   = burst_len_i;
                cnt_d   = 3'd0;
                start_d = 1'b1;
                end_d   = (burst_len_i == 3'd0);
                valid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            owner_q <= 1'b0;
            rr_q    <= 1'b1;
            len_q   <= 3'd0;
            cnt_q   <= 3'd0;
            lock_q  <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            start_q <= start_d;
            end_q   <= end_d;
            valid_q <= valid_d;
            busy_q  <= |gnt_d;
        end
    end
    assign gnt_o         = gnt_q;
    assign burst_start_o = start_q;
    assign burst_end_o   = end_q;
    assign data_valid_o  = valid_q;
    assign busy_o        = busy_q;
endmodule

// File: tb/tb_lock_burst_arbiter.sv
// tb_lock_burst_arbiter: directed vector table plus random traffic checked against a beat-counting model.
module tb_lock_burst_arbiter;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] req_i = 2'b00;
    logic [2:0] burst_len_i = 3'd0;
    logic       lock_i = 1'b0;
    logic       unlock_i = 1'b0;
    logic [1:0] gnt_o;
    logic       burst_start_o, burst_end_o, data_valid_o, busy_o;
    logic [5:0] dut_out;
    int         checks = 0;
    int         errors = 0;
    int         m_owner, m_left, m_first, m_flag, m_last;

    lock_burst_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .burst_len_i(burst_len_i),
        .lock_i(lock_i), .unlock_i(unlock_i), .gnt_o(gnt_o), .burst_start_o(burst_start_o),
        .burst_end_o(burst_end_o), .data_valid_o(data_valid_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;
    assign dut_out = {gnt_o, burst_start_o, burst_end_o, data_valid_o, busy_o};

    typedef struct {
        bit         rst;
        logic [1:0] req;
        logic [2:0] len;
        logic       lock;
        logic       unlock;
        logic [5:0] exp;
    } vec_t;
    vec_t vt[$];

    // Model: owner index (-1 = none), beats still to show, and the lock flag
    function automatic void model_reset();
        m_owner = -1;
        m_left  = 0;
        m_first = 0;
        m_flag  = 0;
        m_last  = 1;
    endfunction

    function automatic void model_step();
        int nf;
        nf = unlock_i ? 0 : ((lock_i && m_owner >= 0) ? 1 : m_flag);
        m_first = 0;
        if (m_owner < 0) begin
            if (req_i != 2'b00) begin
                m_owner = (req_i == 2'b11) ? 1 - m_last : int'(req_i[1]);
                m_last  = m_owner;
                m_left  = int'(burst_len_i) + 1;
                m_first = 1;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && nf == 0) m_owner = -1;
        end else if (unlock_i) begin
            m_owner = -1;
        end else if (req_i[m_owner]) begin
            m_left  = int'(burst_len_i) + 1;
            m_first = 1;
        end
        m_flag = nf;
    endfunction

    function automatic logic [5:0] model_out();
        logic [1:0] g;
        g = (m_owner < 0) ? 2'b00 : (m_owner == 1 ? 2'b10 : 2'b01);
        return {g, (m_first != 0 && m_left > 0), m_left == 1, m_left > 0, m_owner >= 0};
    endfunction

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gnt,bs,be,dv,busy=%b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [1:0] r, input logic [2:0] l, input logic lk, input logic ul);
        req_i = r;
        burst_len_i = l;
        lock_i = lk;
        unlock_i = ul;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_i = 2'b00;
        burst_len_i = 3'd0;
        lock_i = 1'b0;
        unlock_i = 1'b0;
        @(negedge clk_i);
        model_reset();
        chk("reset_state", dut_out, 6'b000000);
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        model_reset();
        // single 4-beat burst, req dropped and burst_len changed mid-burst
        vt.push_back('{1'b1, 2'b01, 3'd3, 1'b0, 1'b0, 6'b011011});
        vt.push_back('{1'b0, 2'b00, 3'd5, 1'b0, 1'b0, 6'b010011});
        vt.push_back('{1'b0, 2'b00, 3'd5, 1'b0, 1'b0, 6'b010011});
        vt.push_back('{1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 6'b010111});
        vt.push_back('{1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 6'b000000});
        // round-robin with both requesting
        vt.push_back('{1'b1, 2'b11, 3'd1, 1'b0, 1'b0, 6'b011011});
        vt.push_back('{1'b0, 2'b11, 3'd1, 1'b0, 1'b0, 6'b010111});
        vt.push_back('{1'b0, 2'b11, 3'd1, 1'b0, 1'b0, 6'b000000});
        vt.push_back('{1'b0, 2'b11, 3'd1, 1'b0, 1'b0, 6'b101011});
        vt.push_back('{1'b0, 2'b11, 3'd1, 1'b0, 1'b0, 6'b100111});
        vt.push_back('{1'b0, 2'b11, 3'd1, 1'b0, 1'b0, 6'b000000});
        vt.push_back('{1'b0, 2'b11, 3'd1, 1'b0, 1'b0, 6'b011011});
        // lock holds the grant against the other requester until unlock
        vt.push_back('{1'b1, 2'b01, 3'd1, 1'b0, 1'b0, 6'b011011});
        vt.push_back('{1'b0, 2'b11, 3'd1, 1'b1, 1'b0, 6'b010111});
        vt.push_back('{1'b0, 2'b10, 3'd1, 1'b0, 1'b0, 6'b010001});
        vt.push_back('{1'b0, 2'b10, 3'd1, 1'b0, 1'b0, 6'b010001});
        vt.push_back('{1'b0, 2'b10, 3'd1, 1'b0, 1'b1, 6'b000000});
        vt.push_back('{1'b0, 2'b10, 3'd1, 1'b0, 1'b0, 6'b101011});
        vt.push_back('{1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 6'b100111});
        vt.push_back('{1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 6'b000000});
        // lock and unlock together: unlock wins
        vt.push_back('{1'b1, 2'b01, 3'd2, 1'b0, 1'b0, 6'b011011});
        vt.push_back('{1'b0, 2'b00, 3'd2, 1'b1, 1'b1, 6'b010011});
        vt.push_back('{1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 6'b010111});
        vt.push_back('{1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 6'b000000});
        // single-beat burst
        vt.push_back('{1'b1, 2'b10, 3'd0, 1'b0, 1'b0, 6'b101111});
        vt.push_back('{1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 6'b000000});
        // locked owner re-bursts with a new length, then unlocks on the last beat
        vt.push_back('{1'b1, 2'b01, 3'd0, 1'b0, 1'b0, 6'b011111});
        vt.push_back('{1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 6'b010001});
        vt.push_back('{1'b0, 2'b01, 3'd2, 1'b0, 1'b0, 6'b011011});
        vt.push_back('{1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 6'b010011});
        vt.push_back('{1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 6'b010111});
        vt.push_back('{1'b0, 2'b00, 3'd0, 1'b0, 1'b1, 6'b000000});
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) do_reset();
            cyc(vt[i].req, vt[i].len, vt[i].lock, vt[i].unlock);
            chk($sformatf("vec%0d", i), dut_out, vt[i].exp);
        end
        // asynchronous reset during beat 2 of 4
        do_reset();
        cyc(2'b01, 3'd3, 1'b0, 1'b0);
        cyc(2'b01, 3'd3, 1'b0, 1'b0);
        chk("beat2_before_reset", dut_out, 6'b010011);
        #2 rst_ni = 1'b0;
        #1 chk("async_reset", dut_out, 6'b000000);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(2'b11, 3'd1, 1'b0, 1'b0);
        chk("after_reset_rr", dut_out, 6'b011011);
        // random traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r = $urandom;
            cyc(r[1:0], r[4:2], r[7:5] == 3'd0, r[11:8] == 4'd0);
            chk($sformatf("rand%0d", i), dut_out, model_out());
            chk("gnt_not_11", {5'b0, gnt_o == 2'b11}, 6'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lock_burst_arbiter.md
LOCK_BURST_ARBITER -- requirements
Module: lock_burst_arbiter

Interface
REQ-001 The block SHALL provide the following ports: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 The block SHALL provide: rst  input  1  asynchronous active-low reset.
REQ-003 The block SHALL provide: req  input  2  per-requester request, bit i = requester i.
REQ-004 The block SHALL provide: burst_len  input  3  beats minus one for the requested burst, 0..7 = 1..8 beats.
REQ-005 The block SHALL provide: lock  input  1  owner asks to keep the grant after the current burst.
REQ-006 The block SHALL provide: unlock  input  1  owner releases a held lock.
REQ-007 The block SHALL provide: gnt  output  2  one-hot grant, or 00 when nobody is granted.
REQ-008 The block SHALL provide: burst_start  output  1  one-cycle pulse on the first beat of a burst.
REQ-009 The block SHALL provide: burst_end  output  1  one-cycle pulse on the last beat of a burst.
REQ-010 The block SHALL provide: data_valid  output  1  high on every beat of a burst.
REQ-011 The block SHALL provide: busy  output  1  high whenever gnt != 00.

Function
REQ-012 All outputs SHALL be registered.
REQ-013 The FSM SHALL have exactly three states: IDLE, BURST and LOCKED.
REQ-014 In IDLE with req != 00 sampled at edge N, the block SHALL, from cycle N+1:
  - enter BURST;
  - drive gnt one-hot to the winner;
  - pulse burst_start;
  - assert data_valid;
  - latch burst_len and the owner index.
REQ-015 Arbitration SHALL be round-robin: on req=11 the requester not granted last wins; after reset requester 0 has priority.
REQ-016 In BURST, data_valid SHALL stay high for exactly burst_len+1 consecutive cycles, with burst_end high on the final beat only.
REQ-017 When burst_len=0, burst_start and burst_end SHALL both be high in the same single cycle.
REQ-018 Dropping req[owner] mid-burst SHALL NOT shorten the burst; a burst is committed once granted.
REQ-019 burst_len changes during a burst SHALL be ignored.
REQ-020 A lock flag SHALL be set when lock=1 is sampled while gnt != 00, and cleared when unlock=1 is sampled.
REQ-021 When lock and unlock are sampled in the same cycle, unlock SHALL take priority and the flag SHALL be cleared.
REQ-022 On the cycle after burst_end:
  - flag set: enter LOCKED, gnt held, data_valid=0;
  - flag clear: enter IDLE, gnt=00.
REQ-023 In LOCKED:
  - unlock=1 → IDLE next cycle with gnt=00;
  - otherwise req[owner]=1 → BURST next cycle with burst_start and a newly latched burst_len, with no arbitration;
  - the other requester SHALL be ignored.
REQ-024 In LOCKED, unlock and req[owner] in the same cycle SHALL resolve as unlock, i.e. go to IDLE.
REQ-025 IDLE SHALL always last at least one cycle between two unlocked grants, with gnt=00 in that cycle.
REQ-026 The round-robin pointer SHALL update to the owner at each new grant made from IDLE.
REQ-027 gnt SHALL never be 11, and gnt SHALL never change while data_valid=1.

Reset
REQ-028 While rst=0, asynchronously and without waiting for clk, the block SHALL:
  - force gnt=00 and burst_start, burst_end, data_valid, busy = 0;
  - set FSM=IDLE;
  - clear the lock flag and beat counter;
  - give priority to requester 0.
REQ-029 Reset asserted mid-burst or in LOCKED SHALL abort the transfer; after rst returns to 1, operation SHALL resume from IDLE on the next rising edge.

Verification
REQ-030 The bench SHALL cover:
  - req=01, burst_len=3 sampled at N → gnt=01 for N+1..N+4; burst_start at N+1; data_valid N+1..N+4; burst_end at N+4; gnt=00 and busy=0 at N+5.
  - req=11 held after reset, burst_len=1 → gnt=01 for 2 beats, one IDLE cycle, then gnt=10 for 2 beats, then gnt=01 again.
  - req=01 with lock=1 mid-burst and req=10 asserted → after burst_end gnt stays 01 with data_valid=0; unlock=1 → gnt=00 next cycle, then gnt=10.
  - lock=1 and unlock=1 in the same burst cycle → gnt=00 the cycle after burst_end.
  - burst_len=0, req=10 → a single beat with burst_start=burst_end=data_valid=1 in the same cycle.
  - rst=0 during beat 2 of 4 → all outputs 0 immediately; release, then req=11 → gnt=01.
